// File: rtl/decode_run_controller_if.sv
// Message/result channel between the decode run controller and router port 0.
// The master side is the controller. The slave side is the router or its FIFO.
interface decode_run_controller_if;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/decode_run_controller.sv
// Runs MAX_COUNT decoding rounds through the root hub's local port. Each round
// sends START and MEAS, then collects leaf results with a timeout and keeps run statistics.
module decode_run_controller #(
  parameter int unsigned NUM_LEAVES     = 1,
  parameter int unsigned MAX_COUNT      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  START_MSG      = 8'h01,
  parameter logic [7:0]  MEAS_HDR       = 8'h02
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          multi_fpga_i,
  decode_run_controller_if.master       bus,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [15:0]                   round_count_o,
  output logic [15:0]                   max_cycles_o,
  output logic [31:0]                   total_cycles_o,
  output logic [15:0]                   timeout_count_o,
  output logic                          error_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   MAX_CNT16  = 16'(MAX_COUNT);
  localparam logic [3:0]    LEAVES4    = 4'(NUM_LEAVES);
  localparam logic [63:0]   MEAS_WORD  = {8'hff, 8'hff, MEAS_HDR, 40'd0};

  typedef enum logic [1:0] {IDLE, SEND_START, SEND_MEAS, WAIT_RESULT} state_t;

  state_t                state_q;
  logic                  mf_q;
  logic [NUM_LEAVES-1:0] mask_q;
  logic [NUM_LEAVES-1:0] mask_d;
  logic [TW-1:0]         timer_q;
  logic                  busy_q, done_q, error_q;
  logic [15:0]           round_count_q, max_cycles_q, timeout_count_q;
  logic [31:0]           total_cycles_q;
  logic                  tx_valid_q, rx_ready_q;
  logic [63:0]           tx_data_q;

  logic [7:0]  rxId;
  logic [15:0] rxCycles;
  logic        accept, newLeaf, badResult, complete, timeoutHit;
  logic [3:0]  hits;
  logic [3:0]  expectedHits;
  logic [32:0] sumWide;
  logic        unusedRxBits;

  function automatic logic [63:0] startWord(input logic mf);
    return {8'hff, 8'hff, START_MSG, 39'd0, mf};
  endfunction

  assign rxId         = bus.rx_data[55:48];
  assign rxCycles     = bus.rx_data[39:24];
  assign unusedRxBits = ^{bus.rx_data[63:56], bus.rx_data[47:40], bus.rx_data[23:0]};

  assign accept       = (state_q == WAIT_RESULT) && rx_ready_q && bus.rx_valid;
  assign expectedHits = mf_q ? 4'd1 : LEAVES4;
  assign sumWide      = {1'b0, total_cycles_q} + {17'd0, rxCycles};

  // A result counts only if its ID is in range and that leaf has not yet answered this round;
  // anything else accepted is flagged as an error.
  always_comb begin
    mask_d  = mask_q;
    newLeaf = 1'b0;
    hits    = 4'd0;
    for (int i = 0; i < int'(NUM_LEAVES); i++) begin
      if (accept && (rxId == 8'(i + 1)) && !mask_q[i]) begin
        mask_d[i] = 1'b1;
        newLeaf   = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_LEAVES); i++) begin
      hits = hits + {3'd0, mask_d[i]};
    end
  end

  assign badResult  = accept && !newLeaf;
  assign complete   = (state_q == WAIT_RESULT) && (hits == expectedHits);
  assign timeoutHit = (state_q == WAIT_RESULT) && (timer_q == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      mf_q            <= 1'b0;
      mask_q          <= '0;
      timer_q         <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      round_count_q   <= 16'd0;
      max_cycles_q    <= 16'd0;
      timeout_count_q <= 16'd0;
      total_cycles_q  <= 32'd0;
      tx_valid_q      <= 1'b0;
      tx_data_q       <= 64'd0;
      rx_ready_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q         <= SEND_START;
            busy_q          <= 1'b1;
            mf_q            <= multi_fpga_i;
            round_count_q   <= 16'd0;
            max_cycles_q    <= 16'd0;
            total_cycles_q  <= 32'd0;
            timeout_count_q <= 16'd0;
            error_q         <= 1'b0;
            tx_valid_q      <= 1'b1;
            tx_data_q       <= startWord(multi_fpga_i);
          end
        end
        SEND_START: begin
          if (bus.tx_ready) begin
            state_q       <= SEND_MEAS;
            round_count_q <= round_count_q + 16'd1;
            tx_data_q     <= MEAS_WORD;
          end
        end
        SEND_MEAS: begin
          if (bus.tx_ready) begin
            state_q    <= WAIT_RESULT;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 64'd0;
            rx_ready_q <= 1'b1;
            mask_q     <= '0;
            timer_q    <= '0;
          end
        end
        WAIT_RESULT: begin
          mask_q  <= mask_d;
          timer_q <= timer_q + 1'b1;
          if (newLeaf) begin
            if (rxCycles > max_cycles_q) max_cycles_q <= rxCycles;
            total_cycles_q <= sumWide[32] ? 32'hFFFF_FFFF : sumWide[31:0];
          end
          if (badResult) error_q <= 1'b1;
          // Completion takes priority over a timeout landing on the same cycle.
          if (complete || timeoutHit) begin
            rx_ready_q <= 1'b0;
            if (!complete) timeout_count_q <= timeout_count_q + 16'd1;
            if (round_count_q < MAX_CNT16) begin
              state_q    <= SEND_START;
              mf_q       <= multi_fpga_i;
              tx_valid_q <= 1'b1;
              tx_data_q  <= startWord(multi_fpga_i);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.rx_ready    = rx_ready_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign round_count_o   = round_count_q;
  assign max_cycles_o    = max_cycles_q;
  assign total_cycles_o  = total_cycles_q;
  assign timeout_count_o = timeout_count_q;

endmodule

// File: tb/tb_decode_run_controller.sv
// Directed bench for decode_run_controller with two leaves, three rounds per run
// and an eight-cycle result timeout.
module tb_decode_run_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        multiFpga;
  logic        busy, done, error;
  logic [15:0] roundCount, maxCycles, timeoutCount;
  logic [31:0] totalCycles;

  int compareCount = 0;
  int failCount    = 0;
  int txCount      = 0;
  int startCount   = 0;

  decode_run_controller_if bus();

  decode_run_controller #(
    .NUM_LEAVES    (2),
    .MAX_COUNT     (3),
    .TIMEOUT_CYCLES(8),
    .START_MSG     (8'h01),
    .MEAS_HDR      (8'h02)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .multi_fpga_i   (multiFpga),
    .bus            (bus.master),
    .busy_o         (busy),
    .done_o         (done),
    .round_count_o  (roundCount),
    .max_cycles_o   (maxCycles),
    .total_cycles_o (totalCycles),
    .timeout_count_o(timeoutCount),
    .error_o        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every word the router side accepts, and the START words among them.
  always @(posedge clk) begin
    if (bus.tx_valid && bus.tx_ready) begin
      txCount++;
      if (bus.tx_data[47:40] == 8'h01) startCount++;
    end
  end

  typedef struct {
    logic        newRound;
    logic [7:0]  id;
    logic [15:0] cyc;
    logic [15:0] expMax;
    logic [31:0] expTotal;
    logic        expErr;
    logic        expTxValid;
    logic        expDone;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [63:0] startWord(input logic mf);
    return {8'hff, 8'hff, 8'h01, 39'd0, mf};
  endfunction

  function automatic logic [63:0] measWord();
    return {8'hff, 8'hff, 8'h02, 40'd0};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitTxValid(input int budget);
    int n = 0;
    while (bus.tx_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tx_valid_wait", {63'd0, bus.tx_valid}, 64'd1);
  endtask

  // Walks one round's START and MEAS transfers (tx_ready high) up to the first rx_ready cycle.
  task automatic beginRound(input logic mf);
    waitTxValid(20);
    checkOutput("start_word", bus.tx_data, startWord(mf));
    @(negedge clk);
    checkOutput("meas_valid", {63'd0, bus.tx_valid}, 64'd1);
    checkOutput("meas_word", bus.tx_data, measWord());
    @(negedge clk);
    checkOutput("rx_ready_open", {63'd0, bus.rx_ready}, 64'd1);
    checkOutput("tx_idle_in_wait", {63'd0, bus.tx_valid}, 64'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] id, input logic [15:0] cyc);
    checkOutput("rx_ready_before_result", {63'd0, bus.rx_ready}, 64'd1);
    bus.rx_data  = {8'h00, id, 8'h33, cyc, 24'h0};
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 64'd0;
  endtask

  task automatic pulseStart(input logic mf);
    start     = 1'b1;
    multiFpga = mf;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    int startsBefore;

    vecs[0] = '{1'b1, 8'd1, 16'd10, 16'd10, 32'd10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'd2, 16'd20, 16'd20, 32'd30, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'd1, 16'd10, 16'd20, 32'd40, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'd2, 16'd20, 16'd20, 32'd60, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'd1, 16'd10, 16'd20, 32'd70, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'd2, 16'd20, 16'd20, 32'd90, 1'b0, 1'b0, 1'b1};

    rst_n        = 1'b0;
    start        = 1'b0;
    multiFpga    = 1'b0;
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 64'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
    checkOutput("reset_tx_data", bus.tx_data, 64'd0);
    checkOutput("reset_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    checkOutput("reset_flags", {61'd0, busy, done, error}, 64'd0);
    checkOutput("reset_counters", {roundCount, maxCycles, timeoutCount, 16'd0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full run: both leaves reply every round.
    $display("[TB] full run, two leaves, three rounds");
    pulseStart(1'b0);
    checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].newRound) beginRound(1'b0);
      applyStimulus(vecs[i].id, vecs[i].cyc);
      checkOutput("max_cycles", {48'd0, maxCycles}, {48'd0, vecs[i].expMax});
      checkOutput("total_cycles", {32'd0, totalCycles}, {32'd0, vecs[i].expTotal});
      checkOutput("error", {63'd0, error}, {63'd0, vecs[i].expErr});
      checkOutput("tx_valid_after_result", {63'd0, bus.tx_valid}, {63'd0, vecs[i].expTxValid});
      checkOutput("done_after_result", {63'd0, done}, {63'd0, vecs[i].expDone});
    end
    checkOutput("run1_busy", {63'd0, busy}, 64'd0);
    checkOutput("run1_round_count", {48'd0, roundCount}, 64'd3);
    checkOutput("run1_tx_words", txCount, 64'd6);
    @(negedge clk);
    checkOutput("done_single_pulse", {63'd0, done}, 64'd0);

    // Back-pressure on START, then every round times out.
    $display("[TB] stalled START and timeouts");
    bus.tx_ready = 1'b0;
    startsBefore = startCount;
    pulseStart(1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_tx_valid", {63'd0, bus.tx_valid}, 64'd1);
      checkOutput("stall_tx_data", bus.tx_data, startWord(1'b0));
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    checkOutput("single_start_transfer", startCount - startsBefore, 64'd1);
    checkOutput("stall_round_count", {48'd0, roundCount}, 64'd1);
    checkOutput("stall_meas_word", bus.tx_data, measWord());
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      if (r > 0) beginRound(1'b0);
      n = 0;
      while (bus.rx_ready === 1'b1 && n < 20) begin
        n++;
        @(negedge clk);
      end
      checkOutput("wait_window_cycles", n, 64'd8);
      checkOutput("timeout_count_step", {48'd0, timeoutCount}, r + 1);
      if (r < 2) checkOutput("restart_after_timeout", {63'd0, bus.tx_valid}, 64'd1);
    end
    checkOutput("timeout_done", {62'd0, done, busy}, 64'd2);
    checkOutput("timeout_stats_cleared", {maxCycles, totalCycles, 16'd0}, 64'd0);
    checkOutput("timeout_round_count", {48'd0, roundCount}, 64'd3);
    @(negedge clk);

    // multi_fpga: a single reply ends the round; the mode is re-latched each round.
    $display("[TB] multi_fpga rounds");
    pulseStart(1'b1);
    multiFpga = 1'b0;
    beginRound(1'b1);
    applyStimulus(8'd2, 16'd7);
    checkOutput("mf_round_end", {63'd0, bus.tx_valid}, 64'd1);
    checkOutput("mf_total", {32'd0, totalCycles}, 64'd7);
    beginRound(1'b0);
    applyStimulus(8'd1, 16'd5);
    checkOutput("mf0_still_waiting", {63'd0, bus.rx_ready}, 64'd1);
    multiFpga = 1'b1;
    applyStimulus(8'd2, 16'd9);
    checkOutput("mf0_max", {48'd0, maxCycles}, 64'd9);
    checkOutput("mf0_total", {32'd0, totalCycles}, 64'd21);
    beginRound(1'b1);
    applyStimulus(8'd1, 16'd3);
    checkOutput("mf_done", {62'd0, done, busy}, 64'd2);
    checkOutput("mf_final_total", {32'd0, totalCycles}, 64'd24);
    checkOutput("mf_timeouts", {48'd0, timeoutCount}, 64'd0);
    @(negedge clk);

    // Duplicate and out-of-range IDs, plus start while busy.
    $display("[TB] bad and duplicate results");
    pulseStart(1'b0);
    beginRound(1'b0);
    applyStimulus(8'd1, 16'd10);
    checkOutput("dup_pre_total", {32'd0, totalCycles}, 64'd10);
    checkOutput("error_cleared_by_start", {63'd0, error}, 64'd0);
    applyStimulus(8'd1, 16'd50);
    checkOutput("dup_error", {63'd0, error}, 64'd1);
    checkOutput("dup_stats", {maxCycles, totalCycles, 16'd0}, {16'd10, 32'd10, 16'd0});
    applyStimulus(8'd5, 16'd60);
    checkOutput("bad_id_stats", {maxCycles, totalCycles, 16'd0}, {16'd10, 32'd10, 16'd0});
    checkOutput("bad_id_still_waiting", {62'd0, bus.rx_ready, bus.tx_valid}, 64'd2);
    pulseStart(1'b0);
    checkOutput("busy_start_ignored_err", {63'd0, error}, 64'd1);
    checkOutput("busy_start_ignored_rc", {48'd0, roundCount}, 64'd1);
    applyStimulus(8'd2, 16'd20);
    checkOutput("leaf2_completes", {63'd0, bus.tx_valid}, 64'd1);
    checkOutput("leaf2_stats", {maxCycles, totalCycles, 16'd0}, {16'd20, 32'd30, 16'd0});

    // Asynchronous reset in the middle of round 2.
    $display("[TB] reset during WAIT_RESULT");
    beginRound(1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_tx", {bus.tx_valid, bus.rx_ready}, 64'd0);
    checkOutput("async_reset_tx_data", bus.tx_data, 64'd0);
    checkOutput("async_reset_flags", {61'd0, busy, done, error}, 64'd0);
    checkOutput("async_reset_counters", {roundCount, maxCycles, timeoutCount, 16'd0}, 64'd0);
    checkOutput("async_reset_total", {32'd0, totalCycles}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulseStart(1'b0);
    beginRound(1'b0);
    checkOutput("fresh_run_round_count", {48'd0, roundCount}, 64'd1);
    checkOutput("fresh_run_busy", {63'd0, busy}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/decode_run_controller.md
# decode_run_controller

Sequences repeated decoding rounds through the root hub's local port. For each round it sends a START_DECODING message and a MEASUREMENT_DATA header to the leaves, then collects one result per expected leaf, with a timeout. It keeps per-run statistics and replaces the free-running test sequencer on router port 0. It never drives leaf ports directly.

## Interface
- NUM_LEAVES, 1: leaf FPGAs behind the root hub (1..8).
- MAX_COUNT, 20: rounds per run (1..2^16-1).
- TIMEOUT_CYCLES, 4096: wait-for-result limit per round (≥2).
- START_MSG, 8'h01: START_DECODING message code.
- MEAS_HDR, 8'h02: MEASUREMENT_DATA header code.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- start  in  1  one-cycle run request; accepted only in IDLE.
- multi_fpga  in  1  level, sampled when a round begins; 1 = one result ends the round.
- tx_data  out  64  message to router port 0 rx.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  router/FIFO accepts.
- rx_data  in  64  result from router port 0 tx.
- rx_valid  in  1  result valid.
- rx_ready  out  1  controller accepts result.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the run ends.
- round_count  out  16  rounds started in the current or last run.
- max_cycles  out  16  largest result cycle field seen this run.
- total_cycles  out  32  saturating sum of result cycle fields.
- timeout_count  out  16  rounds ended by timeout.
- error  out  1  sticky; set on a bad or duplicate result ID; cleared by start.

## Operation
- States: IDLE, SEND_START, SEND_MEAS, WAIT_RESULT.
- IDLE:
  - start=1 moves to SEND_START.
  - Clears round_count, max_cycles, total_cycles, timeout_count and error.
  - busy=1 from the next cycle.
- SEND_START:
  - tx_valid=1.
  - tx_data = {8'hff, 8'hff, START_MSG, 39'b0, mf}, where mf is multi_fpga latched on entry.
  - On tx_valid&&tx_ready: round_count+1, go to SEND_MEAS.
- SEND_MEAS:
  - tx_valid=1, tx_data = {8'hff, 8'hff, MEAS_HDR, 40'b0}.
  - On handshake go to WAIT_RESULT; clear the leaf mask and the timer.
- WAIT_RESULT:
  - rx_ready=1. A result is consumed on rx_valid&&rx_ready.
  - Result fields: [55:48] leaf ID, [47:40] iterations, [39:24] cycles.
  - Leaf ID valid range is 1..NUM_LEAVES.
  - Valid ID with mask bit clear: set the mask bit, update max_cycles and total_cycles (saturate at 32'hFFFF_FFFF).
  - ID out of range, or mask bit already set: consumed, error=1, no statistics update.
  - Round complete when the number of mask bits set equals the expected count (1 if mf, otherwise NUM_LEAVES).
  - Timer counts up every cycle in WAIT_RESULT. At TIMEOUT_CYCLES-1 without completion: timeout_count+1, round ends.
  - Completion and timeout in the same cycle: completion wins; timeout_count unchanged.
- Round end:
  - If round_count < MAX_COUNT, go to SEND_START; mf is re-latched.
  - Otherwise go to IDLE with done=1 for one cycle and busy=0.
- Outside WAIT_RESULT: rx_ready=0.
- In IDLE and WAIT_RESULT: tx_valid=0, tx_data=0.
- start while busy is ignored.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - tx_valid=0, tx_data=0, rx_ready=0.
  - busy=0, done=0, error=0.
- tx_valid, tx_data and rx_ready are Moore outputs decoded from state; no combinational path from any input.
- tx_data is held stable while tx_valid=1 and tx_ready=0.
- Cycle counts:
  - start at cycle 0 → tx_valid=1 at cycle 1.
  - With tx_ready tied high, the START message transfers at cycle 1 and MEAS at cycle 2.
  - rx_ready=1 from cycle 3.
- The last accepted result at cycle N gives one of:
  - next START with tx_valid=1 at cycle N+1, or
  - done=1 and busy=0 at cycle N+1.
- Statistics update on the cycle after the accepting edge.
- Reset asserted mid-round: outputs return to reset values asynchronously. A partially sent message is abandoned; the downstream FIFO owns any word already accepted.

## Test plan
- NUM_LEAVES=2, MAX_COUNT=3, tx_ready=1, leaves 1 and 2 each reply with cycles 10 then 20 every round → 6 tx words, done after the 3rd round, round_count=3, max_cycles=20, total_cycles=90, error=0.
- tx_ready low for 5 cycles during SEND_START → tx_data stable and tx_valid held; exactly one START word transferred.
- multi_fpga=1, one reply from leaf 2 → round ends on that reply; bit 0 of the START word is 1.
- Duplicate reply from leaf 1, then ID 5 with NUM_LEAVES=2 → both consumed, error=1, stats unchanged, round still waits for leaf 2.
- TIMEOUT_CYCLES=8, no replies, MAX_COUNT=2 → timeout_count=2, done pulse, busy=0.
- Reset pulled low during WAIT_RESULT of round 2 → all outputs 0 immediately; a new start begins a fresh run with round_count=1 after the first START transfer.
